// File: rtl/exec_monitor.sv
// exec_monitor: watches the fetch stream, produces a sticky PASS/FAIL/TIMEOUT
// verdict and keeps a ring of the most recent fetched PCs for readout.
// HIST_DEPTH must be at least 2 so the read index port has a non-zero width.
module exec_monitor #(
  parameter int unsigned     XLEN           = 32,
  parameter int unsigned     HIST_DEPTH     = 10,
  parameter int unsigned     TIMEOUT_CYCLES = 50000,
  parameter logic [XLEN-1:0] PASS_WORD      = 'h1,
  parameter logic [XLEN-1:0] FAIL_WORD      = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [XLEN-1:0]                   pc_in,
  input  logic [XLEN-1:0]                   instr_in,
  input  logic                              instr_valid,
  output logic [1:0]                        status,
  output logic                              done,
  output logic [31:0]                       cycle_cnt,
  output logic [$clog2(HIST_DEPTH+1)-1:0]   hist_count,
  input  logic [$clog2(HIST_DEPTH)-1:0]     hist_rd_idx,
  output logic [XLEN-1:0]                   hist_rd_data
);

  localparam int CNT_W = $clog2(HIST_DEPTH + 1);
  localparam int PTR_W = $clog2(HIST_DEPTH);
  // Wide enough for oldest + any read index without overflow.
  localparam int AW    = CNT_W + 2;
  localparam logic [AW-1:0] DEPTH_A = AW'(HIST_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic              hist_we;
  logic [PTR_W-1:0]  wr_ptr;
  logic [XLEN-1:0]   hist [HIST_DEPTH];
  logic [AW-1:0]     oldest_p0;
  logic [PTR_W-1:0]  rd_ptr_p0;
  logic              rd_hit_p0;
  logic [XLEN-1:0]   rd_data_p1;

  function automatic logic [31:0] sat_inc_cyc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(HIST_DEPTH)) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] wrap_inc_ptr(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(HIST_DEPTH - 1)) ? '0 : v + PTR_W'(1);
  endfunction

  // (a - b) mod HIST_DEPTH for a < HIST_DEPTH, b <= HIST_DEPTH.
  function automatic logic [AW-1:0] mod_sub(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a >= b) ? a - b : a + DEPTH_A - b;
  endfunction

  // (a + b) mod HIST_DEPTH; exact whenever b < HIST_DEPTH, which is the only
  // case whose result is used (out-of-range indices read as zero).
  function automatic logic [PTR_W-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW-1:0] s;
    s = a + b;
    return PTR_W'((s >= DEPTH_A) ? s - DEPTH_A : s);
  endfunction

  // Verdict next-state: FAIL beats PASS beats TIMEOUT; terminal states hold.
  always_comb begin
    state_d = state_q;
    hist_we = 1'b0;
    if (state_q == ST_RUN) begin
      hist_we = instr_valid;
      if (instr_valid && (instr_in == FAIL_WORD)) begin
        state_d = ST_FAIL;
      end else if (instr_valid && (instr_in == PASS_WORD)) begin
        state_d = ST_PASS;
      end else if (cycle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  // Verdict register; done is registered alongside so both change together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_d != ST_RUN);
    end
  end

  // Run counters and history bookkeeping; all freeze once a verdict is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt  <= '0;
      wr_ptr     <= '0;
      hist_count <= '0;
    end else begin
      if (state_q == ST_RUN) begin
        cycle_cnt <= sat_inc_cyc(cycle_cnt);
      end
      if (hist_we) begin
        wr_ptr     <= wrap_inc_ptr(wr_ptr);
        hist_count <= sat_inc_cnt(hist_count);
      end
    end
  end

  // History storage has no reset; hist_count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (hist_we) begin
      hist[wr_ptr] <= pc_in;
    end
  end

  // Stage p0: map the oldest-relative read index onto a physical slot.
  always_comb begin
    oldest_p0 = mod_sub(AW'(wr_ptr), AW'(hist_count));
    rd_ptr_p0 = mod_add(oldest_p0, AW'(hist_rd_idx));
    rd_hit_p0 = (AW'(hist_rd_idx) < AW'(hist_count));
  end

  // Stage p1: registered readout, zero for indices past the valid entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_p1 <= '0;
    end else begin
      rd_data_p1 <= rd_hit_p0 ? hist[rd_ptr_p0] : '0;
    end
  end

  assign status       = state_q;
  assign hist_rd_data = rd_data_p1;

endmodule
